// File: rtl/bram_qr_reader_if.sv
// Bundle between bram_qr_reader and its neighbours: command, BRAM_QR read port, output stream.
// master = the reader, slave = the command issuer / memory / stream consumer.
interface bram_qr_reader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_write_en;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    input  start, start_addr, length, mem_data_in, out_ready,
    output busy, done, mem_addr, mem_write_en, out_data, out_valid, out_last
  );

  modport slave (
    output start, start_addr, length, mem_data_in, out_ready,
    input  busy, done, mem_addr, mem_write_en, out_data, out_valid, out_last
  );
endinterface

// File: rtl/bram_qr_reader.sv
// Sweeps a wrap-around BRAM_QR address range and streams the words out through a 2-entry buffer.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_RUN   | issuing reads, reads remaining > 0
//   ST_DRAIN | all reads issued, emptying in-flight read and buffer
module bram_qr_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  bram_qr_reader_if.master   rd_if
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rd_rem_q, rd_rem_d;
  logic [ADDR_WIDTH:0]   emit_rem_q, emit_rem_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic                  done_q, done_d;
  logic                  push, pop, issue;
  logic [1:0]            occ_after;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_rem_d   = rd_rem_q;
    emit_rem_d = emit_rem_q;
    count_d    = count_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    done_d     = 1'b0;

    push = inflight_q;
    pop  = (count_q != 2'd0) && rd_if.out_ready;
    // Occupancy including the in-flight read, after this cycle's pop; never exceeds 2.
    occ_after = count_q + {1'b0, inflight_q} - {1'b0, pop};
    issue = (state_q == ST_RUN) && (rd_rem_q != '0) && (occ_after < 2'd2);
    inflight_d = issue;

    if (issue) begin
      rd_rem_d = rd_rem_q - CNT_ONE;
      if (rd_rem_q != CNT_ONE) addr_d = addr_q + 1'b1;
    end
    if (pop) emit_rem_d = emit_rem_q - CNT_ONE;

    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) buf0_d = rd_if.mem_data_in;
        else                 buf1_d = rd_if.mem_data_in;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        buf0_d  = buf1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          buf0_d = rd_if.mem_data_in;
        end else begin
          buf0_d = buf1_q;
          buf1_d = rd_if.mem_data_in;
        end
      end
      default: ;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (rd_if.start) begin
          if (rd_if.length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = ST_RUN;
            addr_d     = rd_if.start_addr;
            rd_rem_d   = rd_if.length;
            emit_rem_d = rd_if.length;
          end
        end
      end
      ST_RUN: begin
        if (issue && rd_rem_q == CNT_ONE) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!inflight_q && (count_q == 2'd0 || (count_q == 2'd1 && pop))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rd_rem_q   <= '0;
      emit_rem_q <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_rem_q   <= rd_rem_d;
      emit_rem_q <= emit_rem_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      done_q     <= done_d;
    end
  end

  assign rd_if.busy         = (state_q != ST_IDLE);
  assign rd_if.done         = done_q;
  assign rd_if.mem_addr     = addr_q;
  assign rd_if.mem_write_en = 1'b0;
  assign rd_if.out_data     = buf0_q;
  assign rd_if.out_valid    = (count_q != 2'd0);
  assign rd_if.out_last     = (count_q != 2'd0) && (emit_rem_q == CNT_ONE);

endmodule

// File: tb/tb_bram_qr_reader.sv
// Directed bench for bram_qr_reader against a behavioural single-port BRAM_QR (mem[i] = i + 0x10).
module tb_bram_qr_reader;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_qr_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rd_if ();
  bram_qr_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .rd_if(rd_if));

  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (rd_if.mem_write_en) mem[rd_if.mem_addr] <= 8'hEE;
    rd_if.mem_data_in <= mem[rd_if.mem_addr];
  end

  int total = 0;
  int bad   = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  rd_if.busy, 0);
    chk({tag, "_done"},  rd_if.done, 0);
    chk({tag, "_addr"},  rd_if.mem_addr, 0);
    chk({tag, "_we"},    rd_if.mem_write_en, 0);
    chk({tag, "_valid"}, rd_if.out_valid, 0);
    chk({tag, "_last"},  rd_if.out_last, 0);
    chk({tag, "_data"},  rd_if.out_data, 0);
  endtask

  // mode 0: out_ready high; mode 1: toggling pattern. dbl: extra start during the command.
  // abort_after != 0: pulse rst after that many transfers.
  task automatic run_cmd(input logic [AW-1:0] sa, input logic [AW:0] len,
                         input int mode, input bit dbl, input int abort_after);
    int k = 0;
    int ahead;
    bit fin = 1'b0;
    bit aborted = 1'b0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [DW-1:0] pd = '0;
    logic [AW-1:0] ea;
    @(negedge clk);
    rd_if.start      = 1'b1;
    rd_if.start_addr = sa;
    rd_if.length     = len;
    rd_if.out_ready  = (mode == 0) ? 1'b1 : pat[0];
    for (int c = 1; c <= 200 && !fin; c++) begin
      @(negedge clk);
      rd_if.start = dbl && (c == 2);
      if (dbl && c == 2) begin
        rd_if.start_addr = 4'd7;
        rd_if.length     = 5'd3;
      end
      rd_if.out_ready = (mode == 0) ? 1'b1 : pat[c % 6];
      chk("write_en", rd_if.mem_write_en, 0);
      if (c == 1 && len != 0) begin
        chk("busy_c1", rd_if.busy, 1);
        chk("addr_c1", rd_if.mem_addr, sa);
      end
      if (pv && !pr) begin
        chk("stall_data", rd_if.out_data, pd);
        chk("stall_last", rd_if.out_last, pl);
      end
      if (mode == 1) begin
        ahead = int'(AW'(rd_if.mem_addr - sa)) - k;
        chk("addr_ahead", ahead <= 2, 1);
      end
      if (rd_if.out_valid && rd_if.out_ready) begin
        ea = sa + AW'(k);
        chk("data", rd_if.out_data, 8'h10 + {4'h0, ea});
        chk("last", rd_if.out_last, k == int'(len) - 1);
        if (mode == 0) chk("xfer_cycle", c, 3 + k);
        k++;
        if (abort_after != 0 && k == abort_after) begin
          fin = 1'b1;
          aborted = 1'b1;
        end
      end
      if (!aborted && rd_if.done) begin
        chk("done_busy", rd_if.busy, 0);
        chk("word_count", k, len);
        if (mode == 0) chk("done_cycle", c, (len == 0) ? 1 : int'(len) + 3);
        fin = 1'b1;
      end
      pv = rd_if.out_valid;
      pr = rd_if.out_ready;
      pd = rd_if.out_data;
      pl = rd_if.out_last;
    end
    rd_if.start = 1'b0;
    if (!fin) chk("timeout", 0, 1);
    if (aborted) begin
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_outputs("mid_rst");
      repeat (10) begin
        @(negedge clk);
        chk("abort_valid", rd_if.out_valid, 0);
        chk("abort_done", rd_if.done, 0);
      end
    end else begin
      repeat (4) begin
        @(negedge clk);
        chk("post_done", rd_if.done, 0);
        chk("post_valid", rd_if.out_valid, 0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    rst              = 1'b1;
    rd_if.start      = 1'b0;
    rd_if.start_addr = '0;
    rd_if.length     = '0;
    rd_if.out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("reset");

    run_cmd(4'd2,  5'd4,  0, 1'b0, 0);
    run_cmd(4'd2,  5'd4,  1, 1'b0, 0);
    run_cmd(4'd14, 5'd4,  0, 1'b0, 0);
    run_cmd(4'd0,  5'd16, 0, 1'b0, 0);
    run_cmd(4'd5,  5'd0,  0, 1'b0, 0);
    run_cmd(4'd3,  5'd6,  0, 1'b1, 0);
    run_cmd(4'd4,  5'd8,  0, 1'b0, 2);
    run_cmd(4'd9,  5'd3,  0, 1'b0, 0);
    run_cmd(4'd13, 5'd7,  1, 1'b0, 0);

    for (int i = 0; i < 16; i++) chk("mem_intact", mem[i], 8'h10 + 8'(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bram_qr_reader.md
# bram_qr_reader

Read-side client for the single-port `BRAM_QR` query/reference memory (synchronous read, one-cycle latency, `addr`/`write_en`/`data_in`/`data_out`). On a start command it sweeps a contiguous, wrap-around address range and emits each word on a valid/ready stream. It absorbs the memory's read latency and downstream backpressure through a 2-entry output buffer and sustains one word per cycle. It sits between a `BRAM_QR` instance and the alignment datapath that consumes the sequence.

## Interface

**Parameters**
- `ADDR_WIDTH`, 4, memory address width; must match the attached `BRAM_QR`.
- `DATA_WIDTH`, 8, word width; must match the attached `BRAM_QR`.

**Ports**
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  command strobe; sampled only in IDLE.
- `start_addr`  in  ADDR_WIDTH  first address; sampled with `start`.
- `length`  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; sampled with `start`.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle pulse when a command completes.
- `mem_addr`  out  ADDR_WIDTH  to `BRAM_QR.addr`; registered.
- `mem_write_en`  out  1  to `BRAM_QR.write_en`; constant 0.
- `mem_data_in`  in  DATA_WIDTH  from `BRAM_QR.data_out`.
- `out_data`  out  DATA_WIDTH  stream word.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  downstream accepts; a transfer occurs when `out_valid && out_ready`.
- `out_last`  out  1  marks the final word of a command; qualified by `out_valid`.

## Operation

- **State machine**
  - IDLE: on `start` with `length` > 0, go to RUN. On `start` with `length` == 0, stay in IDLE and pulse `done` the next cycle; no stream output.
  - RUN: issue reads until all `length` reads are issued, then go to DRAIN.
  - DRAIN: wait until the in-flight read has landed and the buffer is empty, then pulse `done` and return to IDLE.
- **Command capture:** while not in IDLE, `start` is ignored, and `start_addr`/`length` are not re-sampled.
- **Read issue:** a read is issued in cycle t by driving `mem_addr` = next address during t. The data is valid on `mem_data_in` in t+1 and is written into the buffer at the end of t+1.
  - Issue condition: reads remaining > 0 and (buffer count + in-flight − pop this cycle) < 2.
  - This condition guarantees the buffer never overflows and gives zero bubbles while `out_ready` stays high.
- **Address arithmetic:** the next address is the current address + 1 modulo 2^ADDR_WIDTH; it wraps 2^ADDR_WIDTH−1 → 0.
  - Reads remaining: ADDR_WIDTH+1 bits, loaded with `length`, decremented per issue.
  - Words remaining to emit: a separate counter, used to generate `out_last`.
- **Between issues:** `mem_addr` holds its last value. Data returned from a non-issue cycle is never captured.
- **Output buffer:** 2-entry FIFO in order. `out_data`/`out_valid` come from the head entry. A push and a pop in the same cycle leave the count unchanged.
- **Backpressure:** while `out_valid && !out_ready`, `out_data` and `out_last` hold stable.
- **Reset values:** `busy`=0, `done`=0, `mem_addr`=0, `mem_write_en`=0, `out_valid`=0, `out_last`=0, `out_data`=0. Buffer is empty, counters are 0, state is IDLE.
- **Reset mid-command:** the command is discarded entirely, including buffered and in-flight words. No `done` pulse is generated. The block is in IDLE on the cycle after `rst` deasserts.

## Timing

- `start` sampled at the end of cycle 0 → `busy`=1 and `mem_addr`=`start_addr` in cycle 1 → word appears on `mem_data_in` in cycle 2 → `out_valid`=1 with mem[`start_addr`] in cycle 3.
- With `out_ready` held high, word k is presented in cycle 3+k. For N words, the last transfer occurs in cycle N+2.
- `busy` is high from cycle 1 through the cycle of the final transfer. `done`=1 and `busy`=0 in the following cycle. The earliest next `start` is sampled in that same `done` cycle.
- For `length`=0: `done` pulses in cycle 1, and `busy` stays 0.
- Throughput is 1 word/cycle sustained. After `out_ready` returns high following a stall, output resumes the same cycle from the buffered word, with no bubble.

## Test plan

- **Basic stream:** mem[i]=i+0x10, `start_addr`=2, `length`=4, `out_ready`=1.
  - Output 0x12, 0x13, 0x14, 0x15 in cycles 3–6; `out_last` only on 0x15; `done` in cycle 7.
- **Backpressure:** same command, with `out_ready` toggling 1,0,0,1,0,1,….
  - Every word is delivered exactly once, in order. `out_data` is stable during stalls. `mem_addr` never advances more than 2 words ahead of the last accepted word.
- **Wrap and full range:**
  - `start_addr`=14, `length`=4 → addresses 14, 15, 0, 1.
  - `start_addr`=0, `length`=16 → all 16 words, `out_last` on mem[15].
- **Zero length and busy-start:**
  - `length`=0 → `done` in cycle 1, no `out_valid`.
  - A second `start` during a 6-word command is ignored: exactly 6 words are delivered and one `done` pulse is generated.
- **Reset mid-command:** assert `rst` for 1 cycle after the 2nd transfer of an 8-word command.
  - All outputs read their reset values the next cycle. No further `out_valid` and no `done`.
  - A new command then works normally.
- **Write port:** throughout all of the above, `mem_write_en` stays 0 and memory contents are unchanged.
